riscv_mc_control: RTL and testbench
===================================

// Module: riscv_mc_control
// PURPOSE
//  Main sequencer for the multicycle RV32I core: a Moore FSM (plus Zero/mem_ready qualifiers) that
//  steps the shared-ALU, single-memory datapath through fetch/decode/execute/writeback.
//  Sits beside the multicycle datapath; drives all enables and mux selects.
//  Supports lw, sw, R-ALU, I-ALU, beq/bne, jal, jalr, lui; all other encodings flag illegal.
// PARAMETERS
//  XLEN  32  datapath width (informational; no XLEN-wide ports here)
// PORTS
//  clk          in   1  core clock; all state on rising edge
//  reset        in   1  asynchronous, active-high; forces state FETCH
//  op           in   7  instr[6:0] from instruction register
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30]
//  Zero         in   1  ALU zero flag (current-cycle ALU result)
//  mem_ready    in   1  memory access completes this cycle
//  PCWrite      out  1  PC load enable (PCUpdate | taken branch)
//  AdrSrc       out  1  mem address: 0=PC, 1=Result
//  MemWrite     out  1  data memory write strobe
//  IRWrite      out  1  load IR and OldPC
//  RegWrite     out  1  register file write enable
//  ResultSrc    out  2  00=ALUOut, 01=Data reg, 10=ALUResult
//  ALUSrcA      out  2  00=PC, 01=OldPC, 10=rs1 reg (A), 11=zero
//  ALUSrcB      out  2  00=rs2 reg (WriteData), 01=ImmExt, 10=constant 4
//  ImmSrc       out  3  000=I, 001=S, 010=B, 011=J, 100=U
//  ALUControl   out  4  ALU operation (package encoding)
//  illegal_instr out 1  one-cycle pulse in DECODE on unsupported op/funct3
// BEHAVIOUR
//  Reset: state=FETCH; while reset high every output is 0. First fetch the cycle after release.
//  Outputs decode combinationally from state; unlisted outputs are 0 in each state; ImmSrc always from op.
//  FETCH: AdrSrc=0, A=00, B=10, ADD, ResultSrc=10. Holds while !mem_ready (IRWrite=PCWrite=0);
//    when mem_ready: IRWrite=1, PCWrite=1 -> DECODE.
//  DECODE: A=01, B=01, ADD (branch/jal target into ALUOut). Next by op:
//    0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH,
//    1101111->JAL, 1100111->JALR, 0110111->LUI. Illegal (unknown op; branch funct3 not 000/001;
//    R funct3 011; jalr funct3!=000): illegal_instr=1 -> FETCH, no architectural write.
//  MEMADR: A=10, B=01, ADD -> MEMREAD (lw) / MEMWRITE (sw).
//  MEMREAD: AdrSrc=1, ResultSrc=00; hold until mem_ready -> MEMWB.
//  MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
//  MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; hold (MemWrite stays 1) until mem_ready -> FETCH.
//  EXECR: A=10, B=00, ALU from funct3/funct7b5 -> ALUWB.  EXECI: A=10, B=01, same decode but
//    funct7b5 ignored except funct3=101 (SRAI/SRLI) -> ALUWB.
//  ALU decode: 000 ADD (SUB if R & funct7b5), 001 SLL, 010 SLT, 011 SLTU (I only), 100 XOR,
//    101 SRL/SRA(funct7b5), 110 OR, 111 AND.
//  ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
//  BRANCH: A=10, B=00, SUB, ResultSrc=00; PCWrite = Zero ^ funct3[0] (beq/bne) -> FETCH.
//  JAL: ResultSrc=00, PCWrite=1 (target from DECODE) -> LINK.
//  JALR: A=10, B=01, ADD, ResultSrc=10, PCWrite=1 -> LINK (LSB clear done by datapath).
//  LINK: A=01, B=10, ADD, ResultSrc=10, RegWrite=1 (rd=OldPC+4) -> FETCH.
//  LUI: A=11, B=01, ADD -> ALUWB.
//  Latency (mem_ready=1): lw 5, sw 4, R/I/lui 4, branch 3, jal/jalr 4 cycles.
//  Reset mid-instruction: immediate return to FETCH, outputs 0; no partial write completes.
//  Unreachable state encodings -> FETCH.
// STRUCTURE
//  riscv_pkg: statetype enum (FETCH..LUI), ALU_* codes (ADD 0000, SUB 0001, AND 0010, OR 0011,
//    XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, SLTU 1001), opcode and IMM_* constants.
//  One sub-module: riscv_mc_aludec (funct3, funct7b5, is_rtype -> ALUControl, illegal), combinational.
// TESTING
//  Reset released, mem_ready=1, op=0000011 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite only in cycle 5.
//  sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite high 4 cycles, single FETCH after.
//  beq funct3=000, Zero=1 -> PCWrite=1 in BRANCH; bne with Zero=1 -> PCWrite=0.
//  R-type funct3=101 funct7b5=1 -> ALUControl=1000; I-type funct3=000 funct7b5=1 -> 0000.
//  op=1111111 -> illegal_instr pulse in DECODE, next FETCH, no RegWrite/MemWrite.
//  Assert reset during MEMWB -> all outputs 0 same cycle; FETCH with IRWrite after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RV32I controller:
// FSM states, ALU operation codes, opcodes and immediate-format selects.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LINK     = 4'd12,
        LUI      = 4'd13
    } statetype;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format is a pure function of the opcode, independent of FSM state.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_aludec.sv
// ALU operation decode from funct3/funct7b5 for R- and I-type arithmetic.
// Also flags the R-type funct3 encoding this core does not implement.
module riscv_mc_aludec
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        illegal     = 1'b0;
        alu_control = ALU_ADD;
        case (funct3)
            3'b000: alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_control = ALU_SLL;
            3'b010: alu_control = ALU_SLT;
            3'b011: begin
                alu_control = ALU_SLTU;
                illegal     = is_rtype;
            end
            3'b100: alu_control = ALU_XOR;
            // funct7b5 selects arithmetic shift for both SRA and SRAI
            3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_control = ALU_OR;
            default: alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/riscv_mc_control.sv
// Main sequencer for the multicycle RV32I core: Moore FSM whose outputs decode
// from state (qualified by Zero / mem_ready) and drive all datapath enables and selects.
module riscv_mc_control
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       illegal_instr
);

    statetype   state, state_next;
    logic       is_rtype;
    logic [3:0] alu_dec;
    logic       alu_illegal;
    logic       dec_illegal;

    assign is_rtype = (op == OP_R);

    riscv_mc_aludec u_aludec (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .is_rtype    (is_rtype),
        .alu_control (alu_dec),
        .illegal     (alu_illegal)
    );

    always_comb begin
        dec_illegal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_I, OP_JAL, OP_LUI: dec_illegal = 1'b0;
            OP_R:      dec_illegal = alu_illegal;
            OP_BRANCH: dec_illegal = (funct3[2:1] != 2'b00);
            OP_JALR:   dec_illegal = (funct3 != 3'b000);
            default:   dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (!dec_illegal) begin
                    case (op)
                        OP_LOAD, OP_STORE: state_next = MEMADR;
                        OP_R:      state_next = EXECR;
                        OP_I:      state_next = EXECI;
                        OP_BRANCH: state_next = BRANCH;
                        OP_JAL:    state_next = JAL;
                        OP_JALR:   state_next = JALR;
                        OP_LUI:    state_next = LUI;
                        default:   state_next = FETCH;
                    endcase
                end
            end
            MEMADR:   state_next = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, LUI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JAL, JALR: state_next = LINK;
            LINK:     state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        illegal_instr = 1'b0;
        ImmSrc        = imm_sel(op);
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            DECODE: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 2'b01;
                illegal_instr = dec_illegal;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            ALUWB:    RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = Zero ^ funct3[0];
            end
            // target was computed into ALUOut during DECODE
            JAL:      PCWrite = 1'b1;
            JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            LINK: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegWrite  = 1'b1;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
        // Outputs are forced low for the whole reset window, including mid-instruction.
        if (reset) begin
            PCWrite       = 1'b0;
            AdrSrc        = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            ResultSrc     = 2'b00;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b00;
            ImmSrc        = 3'b000;
            ALUControl    = ALU_ADD;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Scoreboard bench for riscv_mc_control: per-cycle expected output vectors are
// queued with each instruction's stimulus and compared as the FSM steps.
module tb_riscv_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    riscv_mc_control dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, SLT = 4'b0101, SRL = 4'b0111,
                           SRA = 4'b1000, SLTU = 4'b1001, XOR_ = 4'b0100;
    localparam logic [2:0] II = 3'b000, IS = 3'b001, IB = 3'b010, IJ = 3'b011, IU = 3'b100;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
    logic [18:0] dv;
    assign dv = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ImmSrc, ALUControl, illegal_instr};

    int n_checks = 0;
    int n_fail   = 0;
    logic [18:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] ev(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, a, b,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
    endfunction

    function automatic logic [18:0] e_f(input logic [2:0] i, input logic mr);
        return ev(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, i, ADD, 0);
    endfunction
    function automatic logic [18:0] e_d(input logic [2:0] i, input logic ill);
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, i, ADD, ill);
    endfunction

    task automatic push(input string t, input logic [18:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic cyc(input logic mr, input logic z);
        mem_ready = mr;
        Zero      = z;
        @(negedge clk);
        if (exp_q.size() == 0) chk("sb_empty", exp_q.size(), 1);
        else chk(tag_q.pop_front(), dv, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [3:0] alu, input string t);
        set_instr(o, f3, f7);
        push({t, "_f"}, e_f(II, 1));
        push({t, "_d"}, e_d(II, 0));
        if (o == 7'b0110011) push({t, "_ex"}, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, II, alu, 0));
        else                 push({t, "_ex"}, ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, II, alu, 0));
        push({t, "_wb"}, ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, II, ADD, 0));
        repeat (4) cyc(1, 0);
    endtask

    task automatic illegal_case(input logic [6:0] o, input logic [2:0] f3, input logic [2:0] imm,
                                input string t);
        set_instr(o, f3, 0);
        push({t, "_f"}, e_f(imm, 1));
        push({t, "_d"}, e_d(imm, 1));
        repeat (2) cyc(1, 0);
    endtask

    initial begin
        reset = 1'b1;
        set_instr(7'b0100011, 3'b010, 0);
        Zero = 0; mem_ready = 1;
        #1;
        // reset: everything 0, including ImmSrc for a store opcode
        push("rst0", '0); push("rst1", '0);
        repeat (2) cyc(1, 0);
        reset = 1'b0;

        // lw, mem_ready=1: 5 cycles, RegWrite only in last
        set_instr(7'b0000011, 3'b010, 0);
        push("lw_f", e_f(II, 1));
        push("lw_d", e_d(II, 0));
        push("lw_ma", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, II, ADD, 0));
        push("lw_mr", ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, II, ADD, 0));
        push("lw_wb", ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, II, ADD, 0));
        repeat (5) cyc(1, 0);

        // fetch stalls on memory, then sw with 3 wait cycles in MEMWRITE
        set_instr(7'b0100011, 3'b010, 0);
        push("sw_fstall", e_f(IS, 0));
        push("sw_f", e_f(IS, 1));
        push("sw_d", e_d(IS, 0));
        push("sw_ma", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, IS, ADD, 0));
        repeat (4) push("sw_mw", ev(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, IS, ADD, 0));
        cyc(0, 0); cyc(1, 0); cyc(1, 0); cyc(1, 0);
        cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0);

        // lw with a slow data read
        set_instr(7'b0000011, 3'b010, 0);
        push("lwslow_f", e_f(II, 1));
        push("lwslow_d", e_d(II, 0));
        push("lwslow_ma", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, II, ADD, 0));
        repeat (2) push("lwslow_mr", ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, II, ADD, 0));
        push("lwslow_wb", ev(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, II, ADD, 0));
        cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(1, 0);

        alu_instr(7'b0110011, 3'b101, 1, SRA,  "r_sra");
        alu_instr(7'b0110011, 3'b000, 1, SUB,  "r_sub");
        alu_instr(7'b0110011, 3'b100, 0, XOR_, "r_xor");
        alu_instr(7'b0010011, 3'b000, 1, ADD,  "i_addi");
        alu_instr(7'b0010011, 3'b101, 0, SRL,  "i_srli");
        alu_instr(7'b0010011, 3'b101, 1, SRA,  "i_srai");
        alu_instr(7'b0010011, 3'b011, 0, SLTU, "i_sltiu");
        alu_instr(7'b0010011, 3'b010, 1, SLT,  "i_slti");

        // branches: taken beq, not-taken bne, taken bne, not-taken beq
        set_instr(7'b1100011, 3'b000, 0);
        push("beq_f", e_f(IB, 1)); push("beq_d", e_d(IB, 0));
        push("beq_br", ev(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IB, SUB, 0));
        cyc(1, 0); cyc(1, 0); cyc(1, 1);
        set_instr(7'b1100011, 3'b001, 0);
        push("bne_f", e_f(IB, 1)); push("bne_d", e_d(IB, 0));
        push("bne_br", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IB, SUB, 0));
        cyc(1, 0); cyc(1, 0); cyc(1, 1);
        push("bnet_f", e_f(IB, 1)); push("bnet_d", e_d(IB, 0));
        push("bnet_br", ev(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IB, SUB, 0));
        cyc(1, 0); cyc(1, 0); cyc(1, 0);
        set_instr(7'b1100011, 3'b000, 0);
        push("beqn_f", e_f(IB, 1)); push("beqn_d", e_d(IB, 0));
        push("beqn_br", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IB, SUB, 0));
        cyc(1, 0); cyc(1, 0); cyc(1, 0);

        // jal, jalr, lui
        set_instr(7'b1101111, 3'b000, 0);
        push("jal_f", e_f(IJ, 1)); push("jal_d", e_d(IJ, 0));
        push("jal_j", ev(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, IJ, ADD, 0));
        push("jal_lk", ev(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, IJ, ADD, 0));
        repeat (4) cyc(1, 0);
        set_instr(7'b1100111, 3'b000, 0);
        push("jalr_f", e_f(II, 1)); push("jalr_d", e_d(II, 0));
        push("jalr_j", ev(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, II, ADD, 0));
        push("jalr_lk", ev(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, II, ADD, 0));
        repeat (4) cyc(1, 0);
        set_instr(7'b0110111, 3'b000, 0);
        push("lui_f", e_f(IU, 1)); push("lui_d", e_d(IU, 0));
        push("lui_ex", ev(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, IU, ADD, 0));
        push("lui_wb", ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, IU, ADD, 0));
        repeat (4) cyc(1, 0);

        // illegal encodings: pulse in DECODE, straight back to FETCH
        illegal_case(7'b1111111, 3'b000, II, "ill_op");
        illegal_case(7'b0110011, 3'b011, II, "ill_r011");
        illegal_case(7'b1100011, 3'b100, IB, "ill_br100");
        illegal_case(7'b1100111, 3'b001, II, "ill_jalr");
        illegal_case(7'b0000000, 3'b000, II, "ill_zero");

        // reset asserted while in MEMWB: outputs drop the same cycle
        set_instr(7'b0000011, 3'b010, 0);
        push("rwb_f", e_f(II, 1)); push("rwb_d", e_d(II, 0));
        push("rwb_ma", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, II, ADD, 0));
        push("rwb_mr", ev(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, II, ADD, 0));
        repeat (4) cyc(1, 0);
        reset = 1'b1;
        push("rwb_rst", '0);
        cyc(1, 0);
        reset = 1'b0;
        set_instr(7'b0110011, 3'b000, 0);
        push("rwb_refetch", e_f(II, 1)); push("rwb_d2", e_d(II, 0));
        push("rwb_ex", ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, II, ADD, 0));
        push("rwb_wb", ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, II, ADD, 0));
        repeat (4) cyc(1, 0);

        chk("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
